button_debouncer: RTL and testbench
===================================

# button_debouncer

Upstream conditioning stage for the counter datapath. It takes a raw, bouncing push-button or switch input and synchronises it to `clock`. It filters the input with a stability counter and produces a clean debounced level plus single-cycle press/release pulses. `press_pulse` is wired directly to the counter's `enable`, so one physical press advances the count by exactly one.

## Interface

**Parameters**
- `STABLE_CYCLES`, default 1000: consecutive cycles the synchronised input must hold a new value before it is accepted. Legal range ≥ 2.
- `CNT_WIDTH`, default 10: width of the stability counter. Must satisfy 2^CNT_WIDTH ≥ STABLE_CYCLES.

**Ports**
- `clock`, input, 1: single clock domain; all flops are rising-edge triggered.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `btn_in`, input, 1: raw asynchronous button input, active-high.
- `btn_level`, output, 1: debounced button level, registered.
- `press_pulse`, output, 1: one-cycle strobe on an accepted 0→1 transition, registered.
- `release_pulse`, output, 1: one-cycle strobe on an accepted 1→0 transition, registered.
- `bounce_count`, output, 8: saturating count of aborted stability checks, registered.

## Operation

- **Synchroniser:** two-flop chain `btn_in → sync1 → sync2`. Only `sync2` is used downstream. No logic sits between the two flops.
- **FSM states:** RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK.
  - **RELEASED:** if `sync2` = 1, go to PRESS_CHK and set `cnt` = 0.
  - **PRESS_CHK:**
    - If `sync2` = 0, go to RELEASED and increment `bounce_count`.
    - Else if `cnt` = STABLE_CYCLES−1, go to PRESSED, set `btn_level` = 1 and `press_pulse` = 1.
    - Else `cnt` = `cnt`+1.
  - **PRESSED:** if `sync2` = 0, go to RELEASE_CHK and set `cnt` = 0.
  - **RELEASE_CHK:**
    - If `sync2` = 1, go to PRESSED and increment `bounce_count`.
    - Else if `cnt` = STABLE_CYCLES−1, go to RELEASED, set `btn_level` = 0 and `release_pulse` = 1.
    - Else `cnt` = `cnt`+1.
- **Pulse width:** `press_pulse` and `release_pulse` are high for exactly one cycle and are 0 in every other cycle. They are never high in the same cycle.
- **`bounce_count`:** increments by 1 per aborted check and saturates at 255; it never wraps. It is cleared only by reset.
- **`cnt` and `btn_level`:**
  - `cnt` is only meaningful in the CHK states. Its value in the other states is don't-care but must be deterministic.
  - `btn_level` reflects the state: 1 in PRESSED and RELEASE_CHK, 0 otherwise.
- **Reset values:** asynchronous assertion of `reset_n` = 0 immediately clears everything: `sync1`, `sync2`, FSM = RELEASED, `cnt` = 0, `btn_level` = 0, `press_pulse` = 0, `release_pulse` = 0, `bounce_count` = 0. This applies mid-check or mid-press as well. No release pulse is generated by reset.
- **Button held through reset:** after `reset_n` deasserts with the button held, the press is re-detected after the full latency and a new `press_pulse` is issued.

## Timing

- **Press latency:** let edge k be the first rising edge sampling `btn_in` = 1, with `btn_in` held high afterwards.
  - `sync2` = 1 after edge k+1.
  - FSM enters PRESS_CHK at edge k+2.
  - FSM enters PRESSED at edge k+2+STABLE_CYCLES, where `btn_level` rises and `press_pulse` is high for the following cycle.
  - Total: STABLE_CYCLES+3 edges, counting edge k as edge 1.
- **Release latency:** symmetric with the press latency. `release_pulse` is high for the one cycle after edge k+2+STABLE_CYCLES, where k is the first edge sampling `btn_in` = 0.
- **Bounce handling:** any `sync2` glitch during a check aborts it in that same edge. The next check restarts from `cnt` = 0 and requires a full STABLE_CYCLES of stability.
- **Minimum pulse spacing:** two accepted transitions are at least STABLE_CYCLES+1 cycles apart, so `press_pulse` can never be high in consecutive cycles.
- **Saturation:** a bounce occurring while `bounce_count` = 255 leaves it at 255. The FSM transition still happens normally.

## Test plan

All scenarios use STABLE_CYCLES = 4, CNT_WIDTH = 3, and a 10 ns clock.

1. **Reset:** hold `reset_n` = 0 for 5 cycles while toggling `btn_in` every cycle → all outputs 0 throughout. They remain 0 for 2 cycles after `reset_n` = 1 with `btn_in` = 0.
2. **Clean press then release:** `btn_in` 0→1 first sampled at edge k, held 20 cycles, then 1→0 first sampled at edge m and held → expect:
   - `press_pulse` high for exactly one cycle after edge k+6, and `btn_level` = 1 from edge k+6.
   - `release_pulse` high for one cycle after edge m+6, and `btn_level` = 0 from edge m+6.
   - `bounce_count` = 0.
3. **Bouncy press:** `btn_in` pattern of 2 cycles high / 1 low, repeated 3 times, then held high → expect `bounce_count` = 3, exactly one `press_pulse`, and the pulse coming 6 edges after the final rise is first sampled.
4. **Bouncy release:** from PRESSED, 2 cycles low / 1 high, repeated 2 times, then held low → expect `bounce_count` +2, exactly one `release_pulse`, and no `press_pulse`.
5. **Saturation:** generate 300 aborted press checks (`btn_in` high 2 cycles / low 3 cycles) → expect `bounce_count` = 255 and holding, with `btn_level` still 0.
6. **Reset mid-operation:**
   - Assert `reset_n` = 0 for 2 cycles while in PRESSED with the button held → `btn_level` = 0 asynchronously, with no `release_pulse`.
   - After reset is released → `btn_level` and `press_pulse` reassert 6 edges after the first post-reset sampling edge.
   - Counter-enable check: one pulse advances the downstream counter by exactly 1.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stability-counting FSM, and
// registered level plus single-cycle press/release strobes with a bounce counter.
module button_debouncer #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_WIDTH     = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_in,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] bounce_count
);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 rel_q, rel_d;
    logic [7:0]           bounce_q, bounce_d;
    logic                 cnt_done;
    logic                 aborted;

    assign cnt_done = (cnt_q == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= RELEASED;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            bounce_q <= 8'd0;
        end else begin
            sync1_q  <= btn_in;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            bounce_q <= bounce_d;
        end
    end

    // cnt is parked at zero outside the check states so it stays deterministic.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            RELEASED: begin
                if (sync2_q) state_d = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!sync2_q)      state_d = RELEASED;
                else if (cnt_done) state_d = PRESSED;
                else               cnt_d   = cnt_q + 1'b1;
            end
            PRESSED: begin
                if (!sync2_q) state_d = RELEASE_CHK;
            end
            RELEASE_CHK: begin
                if (sync2_q)       state_d = PRESSED;
                else if (cnt_done) state_d = RELEASED;
                else               cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = RELEASED;
        endcase
    end

    always_comb begin
        level_d  = (state_d == PRESSED) || (state_d == RELEASE_CHK);
        press_d  = (state_q == PRESS_CHK)   && (state_d == PRESSED);
        rel_d    = (state_q == RELEASE_CHK) && (state_d == RELEASED);
        aborted  = ((state_q == PRESS_CHK)   && (state_d == RELEASED)) ||
                   ((state_q == RELEASE_CHK) && (state_d == PRESSED));
        bounce_d = bounce_q;
        if (aborted && (bounce_q != 8'hFF)) bounce_d = bounce_q + 8'd1;
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign bounce_count  = bounce_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4: reset, clean and
// bouncy transitions, bounce saturation, and reset while pressed.
module tb_button_debouncer;

    logic       clock;
    logic       reset_n;
    logic       btn_in;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic [7:0] bounce_count;

    int checks = 0;
    int errors = 0;
    int n_press = 0;
    int n_rel = 0;
    logic prev_press = 1'b0;
    int ds_ctr;

    button_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(3)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_in       (btn_in),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .bounce_count (bounce_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Downstream counter whose enable is press_pulse.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)         ds_ctr <= 0;
        else if (press_pulse) ds_ctr <= ds_ctr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic lvl, input logic pp,
                           input logic rp, input logic [7:0] bc);
        chk({tag, ".level"},   {31'd0, btn_level},     {31'd0, lvl});
        chk({tag, ".press"},   {31'd0, press_pulse},   {31'd0, pp});
        chk({tag, ".release"}, {31'd0, release_pulse}, {31'd0, rp});
        chk({tag, ".bounce"},  {24'd0, bounce_count},  {24'd0, bc});
    endtask

    // Advance n cycles, sampling 1 ns after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (press_pulse === 1'b1)   n_press++;
            if (release_pulse === 1'b1) n_rel++;
            chk("pulse_exclusive", {31'd0, press_pulse & release_pulse}, 32'd0);
            chk("press_not_back_to_back", {31'd0, press_pulse & prev_press}, 32'd0);
            prev_press = press_pulse;
        end
    endtask

    initial begin
        btn_in  = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;

        // 1: reset with toggling input
        for (int i = 0; i < 5; i++) begin
            btn_in = ~btn_in;
            tick(1);
            chk_all("rst_hold", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        btn_in  = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1);
            chk_all("rst_after", 1'b0, 1'b0, 1'b0, 8'd0);
        end
        tick(3);

        // 2: clean press then release
        n_press = 0; n_rel = 0;
        btn_in = 1'b1;
        tick(6);
        chk_all("clean_press_k5", 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        chk_all("clean_press_k6", 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1);
        chk_all("clean_press_k7", 1'b1, 1'b0, 1'b0, 8'd0);
        tick(12);
        btn_in = 1'b0;
        tick(6);
        chk_all("clean_rel_m5", 1'b1, 1'b0, 1'b0, 8'd0);
        tick(1);
        chk_all("clean_rel_m6", 1'b0, 1'b0, 1'b1, 8'd0);
        tick(1);
        chk_all("clean_rel_m7", 1'b0, 1'b0, 1'b0, 8'd0);
        tick(5);
        chk("clean_press_count", n_press, 1);
        chk("clean_rel_count", n_rel, 1);

        // 3: bouncy press, 2 high / 1 low x3, then held
        n_press = 0; n_rel = 0;
        for (int i = 0; i < 3; i++) begin
            btn_in = 1'b1; tick(2);
            btn_in = 1'b0; tick(1);
        end
        btn_in = 1'b1;
        tick(6);
        chk_all("bouncy_press_k5", 1'b0, 1'b0, 1'b0, 8'd3);
        tick(1);
        chk_all("bouncy_press_k6", 1'b1, 1'b1, 1'b0, 8'd3);
        tick(5);
        chk("bouncy_press_count", n_press, 1);

        // 4: bouncy release, 2 low / 1 high x2, then held
        n_press = 0; n_rel = 0;
        for (int i = 0; i < 2; i++) begin
            btn_in = 1'b0; tick(2);
            btn_in = 1'b1; tick(1);
        end
        btn_in = 1'b0;
        tick(6);
        chk_all("bouncy_rel_k5", 1'b1, 1'b0, 1'b0, 8'd5);
        tick(1);
        chk_all("bouncy_rel_k6", 1'b0, 1'b0, 1'b1, 8'd5);
        tick(5);
        chk("bouncy_rel_count", n_rel, 1);
        chk("bouncy_rel_no_press", n_press, 0);

        // 5: saturation, 2 high / 3 low aborts the press check every time
        n_press = 0; n_rel = 0;
        for (int i = 0; i < 300; i++) begin
            btn_in = 1'b1; tick(2);
            btn_in = 1'b0; tick(3);
            if (i == 248) chk("sat_254", {24'd0, bounce_count}, 32'd254);
            if (i == 249) chk("sat_255", {24'd0, bounce_count}, 32'd255);
        end
        chk_all("sat_hold", 1'b0, 1'b0, 1'b0, 8'd255);
        chk("sat_no_press", n_press, 0);

        // 6: reset while pressed with button held
        btn_in = 1'b1;
        tick(12);
        chk("pressed_before_rst", {31'd0, btn_level}, 32'd1);
        n_press = 0; n_rel = 0;
        reset_n = 1'b0;
        #1;
        chk_all("rst_async", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("rst_async_ctr", ds_ctr, 0);
        tick(2);
        chk_all("rst_mid_hold", 1'b0, 1'b0, 1'b0, 8'd0);
        reset_n = 1'b1;
        tick(6);
        chk_all("rst_redetect_k5", 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        chk_all("rst_redetect_k6", 1'b1, 1'b1, 1'b0, 8'd0);
        chk("ctr_before_pulse", ds_ctr, 0);
        tick(1);
        chk("ctr_after_pulse", ds_ctr, 1);
        tick(10);
        chk("ctr_stays", ds_ctr, 1);
        chk("rst_no_release", n_rel, 0);
        chk("rst_one_press", n_press, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
